// File: rtl/snoop_delay_engine.sv
// snoop_delay_engine
//   Accepts one ACE snoop at a time and classifies it against NUM_FILTERS
//   address/ACSNOOP filter slots. It then drives CRRESP and a CD_BEATS-beat
//   CD burst. On a hit it inserts i_delay idle cycles before CRVALID
//   (target 0), before the first CDVALID (target 1) or before CDLAST (target 2).
//   Arming modes: one-shot, continuous and counted.
//
// Ports
//   ace_aclk, ace_areset           clock, synchronous active-high reset
//   i_enable                       arm request (rising edge arms, low disarms)
//   i_mode, i_target, i_delay      arming mode, delay target, delay length
//   i_shot_count                   shots for counted mode
//   i_flt_*                        per-slot enable, ACSNOOP compare, range
//   i_snoop_valid/o_snoop_ready    snoop handshake with i_acaddr, i_acsnoop,
//                                  i_crresp, i_has_data, i_cddata
//   o_crvalid/i_crready, o_crresp  CR channel
//   o_cdvalid/i_cdready, o_cddata, o_cdlast   CD channel
//   o_state, o_armed, o_done, o_shots_left    status
//
// Optional feature macro: SNOOP_DELAY_STATS_EN adds the saturating
// o_hit_count / o_miss_count statistics outputs.
module snoop_delay_engine #(
  parameter int unsigned ADDR_WIDTH  = 44,
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned DELAY_WIDTH = 32,
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned CD_BEATS    = 4
) (
  input  logic                              ace_aclk,
  input  logic                              ace_areset,
  input  logic                              i_enable,
  input  logic [1:0]                        i_mode,
  input  logic [1:0]                        i_target,
  input  logic [DELAY_WIDTH-1:0]            i_delay,
  input  logic [15:0]                       i_shot_count,
  input  logic [NUM_FILTERS-1:0]            i_flt_en,
  input  logic [NUM_FILTERS-1:0]            i_flt_snp_en,
  input  logic [4*NUM_FILTERS-1:0]          i_flt_acsnoop,
  input  logic [ADDR_WIDTH*NUM_FILTERS-1:0] i_flt_base,
  input  logic [ADDR_WIDTH*NUM_FILTERS-1:0] i_flt_size,
  input  logic                              i_snoop_valid,
  output logic                              o_snoop_ready,
  input  logic [ADDR_WIDTH-1:0]             i_acaddr,
  input  logic [3:0]                        i_acsnoop,
  input  logic [4:0]                        i_crresp,
  input  logic                              i_has_data,
  input  logic [DATA_WIDTH-1:0]             i_cddata,
  output logic                              o_crvalid,
  input  logic                              i_crready,
  output logic [4:0]                        o_crresp,
  output logic                              o_cdvalid,
  input  logic                              i_cdready,
  output logic [DATA_WIDTH-1:0]             o_cddata,
  output logic                              o_cdlast,
  output logic [2:0]                        o_state,
  output logic                              o_armed,
  output logic                              o_done,
  output logic [15:0]                       o_shots_left
`ifdef SNOOP_DELAY_STATS_EN
  ,
  output logic [31:0]                       o_hit_count,
  output logic [31:0]                       o_miss_count
`endif
);

  localparam int unsigned BW = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(CD_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILTER = 3'd1,
    S_DELAY  = 3'd2,
    S_CR     = 3'd3,
    S_CD     = 3'd4,
    S_END    = 3'd5
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0]  addr_l;
  logic [3:0]             snp_l;
  logic [4:0]             crresp_l;
  logic                   has_data_l;
  logic [DATA_WIDTH-1:0]  cddata_l;
  logic                   hit_l;
  logic [1:0]             tgt_l;
  logic [DELAY_WIDTH-1:0] delay_l;
  logic [DELAY_WIDTH-1:0] cnt, cnt_n;
  logic [BW-1:0]          beat, beat_n;
  logic                   enable_q;
  logic [1:0]             mode_l;
  logic                   arm_edge;
  logic                   any_match;
  logic                   hit_c;
  logic                   delay_at_beat0;
  logic [ADDR_WIDTH-1:0]  base_k, size_k;
  logic [ADDR_WIDTH:0]    lo_k, hi_k, addr_x;

  assign arm_edge = i_enable && !enable_q;
  assign o_state  = state;

  // Range compare is one bit wider than the address so base+size never wraps.
  always_comb begin
    any_match = 1'b0;
    base_k    = '0;
    size_k    = '0;
    lo_k      = '0;
    hi_k      = '0;
    addr_x    = {1'b0, addr_l};
    for (int unsigned k = 0; k < NUM_FILTERS; k++) begin
      base_k = i_flt_base[k*ADDR_WIDTH +: ADDR_WIDTH];
      size_k = i_flt_size[k*ADDR_WIDTH +: ADDR_WIDTH];
      lo_k   = {1'b0, base_k};
      hi_k   = {1'b0, base_k} + {1'b0, size_k};
      if (i_flt_en[k] &&
          (!i_flt_snp_en[k] || (snp_l == i_flt_acsnoop[k*4 +: 4])) &&
          ((size_k == '0) || ((addr_x >= lo_k) && (addr_x < hi_k))))
        any_match = 1'b1;
    end
    hit_c = o_armed && (any_match || (i_flt_en == '0)) && (i_target != 2'd3);
  end

  // With a single beat, targets 1 and 2 both delay beat 0, entered from CR.
  assign delay_at_beat0 = hit_l && (delay_l != '0) &&
                          ((tgt_l == 2'd1) || ((tgt_l == 2'd2) && (CD_BEATS == 1)));

  always_ff @(posedge ace_aclk) begin
    if (ace_areset) state <= S_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    beat_n  = beat;
    case (state)
      S_IDLE: begin
        if (i_snoop_valid && o_snoop_ready) state_n = S_FILTER;
      end
      S_FILTER: begin
        beat_n = '0;
        if (hit_c && (i_target == 2'd0) && (i_delay != '0)) begin
          state_n = S_DELAY;
          cnt_n   = i_delay - DELAY_WIDTH'(1);
        end else begin
          state_n = S_CR;
        end
      end
      S_DELAY: begin
        if (cnt == '0) state_n = (tgt_l == 2'd0) ? S_CR : S_CD;
        else           cnt_n   = cnt - DELAY_WIDTH'(1);
      end
      S_CR: begin
        if (i_crready) begin
          if (!has_data_l) begin
            state_n = S_END;
          end else if (delay_at_beat0) begin
            state_n = S_DELAY;
            cnt_n   = delay_l - DELAY_WIDTH'(1);
          end else begin
            state_n = S_CD;
          end
        end
      end
      S_CD: begin
        if (i_cdready) begin
          if (beat == LAST_BEAT) begin
            state_n = S_END;
          end else begin
            beat_n = beat + BW'(1);
            if (hit_l && (tgt_l == 2'd2) && (delay_l != '0) &&
                (beat + BW'(1) == LAST_BEAT)) begin
              state_n = S_DELAY;
              cnt_n   = delay_l - DELAY_WIDTH'(1);
            end
          end
        end
      end
      S_END:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ace_aclk) begin
    if (ace_areset) begin
      addr_l        <= '0;
      snp_l         <= '0;
      crresp_l      <= '0;
      has_data_l    <= 1'b0;
      cddata_l      <= '0;
      hit_l         <= 1'b0;
      tgt_l         <= '0;
      delay_l       <= '0;
      cnt           <= '0;
      beat          <= '0;
      enable_q      <= 1'b0;
      mode_l        <= '0;
      o_armed       <= 1'b0;
      o_shots_left  <= '0;
      o_snoop_ready <= 1'b0;
      o_crvalid     <= 1'b0;
      o_crresp      <= '0;
      o_cdvalid     <= 1'b0;
      o_cddata      <= '0;
      o_cdlast      <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      beat     <= beat_n;
      enable_q <= i_enable;
      if ((state == S_IDLE) && i_snoop_valid && o_snoop_ready) begin
        addr_l     <= i_acaddr;
        snp_l      <= i_acsnoop;
        crresp_l   <= i_crresp;
        has_data_l <= i_has_data;
        cddata_l   <= i_cddata;
      end
      if (state == S_FILTER) begin
        hit_l   <= hit_c;
        tgt_l   <= i_target;
        delay_l <= i_delay;
      end
      // Outputs are registered from the next state so they line up with it.
      o_snoop_ready <= (state_n == S_IDLE);
      o_crvalid     <= (state_n == S_CR);
      o_crresp      <= (state_n == S_CR) ? crresp_l : '0;
      o_cdvalid     <= (state_n == S_CD);
      o_cddata      <= (state_n == S_CD) ? cddata_l : '0;
      o_cdlast      <= (state_n == S_CD) && (beat_n == LAST_BEAT);
      o_done        <= (state_n == S_END);
      // An arming edge takes priority over a same-cycle END disarm.
      if (!i_enable) begin
        o_armed <= 1'b0;
      end else if (arm_edge) begin
        o_armed      <= !((i_mode == 2'd2) && (i_shot_count == '0));
        o_shots_left <= i_shot_count;
        mode_l       <= i_mode;
      end else if ((state == S_END) && hit_l) begin
        if (mode_l == 2'd0) begin
          o_armed <= 1'b0;
        end else if ((mode_l == 2'd2) && (o_shots_left != '0)) begin
          o_shots_left <= o_shots_left - 16'd1;
          if (o_shots_left == 16'd1) o_armed <= 1'b0;
        end
      end
    end
  end

`ifdef SNOOP_DELAY_STATS_EN
  always_ff @(posedge ace_aclk) begin
    if (ace_areset || arm_edge) begin
      o_hit_count  <= '0;
      o_miss_count <= '0;
    end else if (state == S_FILTER) begin
      if (hit_c) begin
        if (o_hit_count != '1) o_hit_count <= o_hit_count + 32'd1;
      end else begin
        if (o_miss_count != '1) o_miss_count <= o_miss_count + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_snoop_delay_engine.sv
// Directed testbench for snoop_delay_engine (default parameters, CD_BEATS=4).
module tb_snoop_delay_engine;
  localparam int unsigned AW  = 44;
  localparam int unsigned DW  = 128;
  localparam int unsigned DLW = 32;
  localparam int unsigned NF  = 4;
  localparam int unsigned NB  = 4;

  logic              clk = 1'b0;
  logic              ace_areset;
  logic              i_enable;
  logic [1:0]        i_mode, i_target;
  logic [DLW-1:0]    i_delay;
  logic [15:0]       i_shot_count;
  logic [NF-1:0]     i_flt_en, i_flt_snp_en;
  logic [4*NF-1:0]   i_flt_acsnoop;
  logic [AW*NF-1:0]  i_flt_base, i_flt_size;
  logic              i_snoop_valid, o_snoop_ready;
  logic [AW-1:0]     i_acaddr;
  logic [3:0]        i_acsnoop;
  logic [4:0]        i_crresp, o_crresp;
  logic              i_has_data;
  logic [DW-1:0]     i_cddata, o_cddata;
  logic              o_crvalid, i_crready, o_cdvalid, i_cdready, o_cdlast;
  logic [2:0]        o_state;
  logic              o_armed, o_done;
  logic [15:0]       o_shots_left;
`ifdef SNOOP_DELAY_STATS_EN
  logic [31:0]       o_hit_count, o_miss_count;
`endif

  snoop_delay_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DELAY_WIDTH(DLW),
    .NUM_FILTERS(NF), .CD_BEATS(NB)
  ) dut (
    .ace_aclk(clk), .ace_areset(ace_areset), .i_enable(i_enable),
    .i_mode(i_mode), .i_target(i_target), .i_delay(i_delay),
    .i_shot_count(i_shot_count), .i_flt_en(i_flt_en), .i_flt_snp_en(i_flt_snp_en),
    .i_flt_acsnoop(i_flt_acsnoop), .i_flt_base(i_flt_base), .i_flt_size(i_flt_size),
    .i_snoop_valid(i_snoop_valid), .o_snoop_ready(o_snoop_ready),
    .i_acaddr(i_acaddr), .i_acsnoop(i_acsnoop), .i_crresp(i_crresp),
    .i_has_data(i_has_data), .i_cddata(i_cddata),
    .o_crvalid(o_crvalid), .i_crready(i_crready), .o_crresp(o_crresp),
    .o_cdvalid(o_cdvalid), .i_cdready(i_cdready), .o_cddata(o_cddata),
    .o_cdlast(o_cdlast), .o_state(o_state), .o_armed(o_armed),
    .o_done(o_done), .o_shots_left(o_shots_left)
`ifdef SNOOP_DELAY_STATS_EN
    , .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Results of the most recent snoop, as cycle numbers relative to the
  // handshake cycle (cycle 0).
  int          r_cr, r_last, r_done, r_nbeats;
  int          r_cd[NB];
  logic [2:0]  r_st1;
  logic        r_armed_done;
  logic [4:0]  exp_crresp;
  logic [DW-1:0] exp_cddata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rising edge of i_enable; returns at a falling edge, engine idle.
  task automatic arm();
    i_enable = 1'b0;
    @(negedge clk);
    i_enable = 1'b1;
    @(negedge clk);
  endtask

  // Issues one snoop from a falling edge with o_snoop_ready high and runs it
  // until the engine is ready again. crready is held low for the first
  // 'stall' cycles that crvalid is up. Captured inputs are scrambled after
  // the handshake to prove they were latched.
  task automatic do_snoop(input logic [AW-1:0] a, input logic [3:0] s,
                          input logic hd, input int stall);
    int cyc;
    int nb;
    int stall_left;
    r_cr = -1; r_last = -1; r_done = -1; r_armed_done = 1'bx; r_st1 = 'x;
    for (int i = 0; i < NB; i++) r_cd[i] = -1;
    nb = 0;
    stall_left = stall;
    i_acaddr = a; i_acsnoop = s; i_has_data = hd;
    i_crresp = exp_crresp; i_cddata = exp_cddata;
    i_crready = (stall == 0);
    i_snoop_valid = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      i_snoop_valid = 1'b0;
      i_crresp = ~exp_crresp;
      i_cddata = ~exp_cddata;
      if (cyc == 1) r_st1 = o_state;
      if (o_crvalid) begin
        if (r_cr < 0) begin
          r_cr = cyc;
          chk("cr_resp", o_crresp, exp_crresp);
        end
        if (stall_left > 0) begin
          chk("cr_stall_resp", o_crresp, exp_crresp);
          stall_left--;
          if (stall_left == 0) i_crready = 1'b1;
        end
      end
      if (o_cdvalid && i_cdready) begin
        if (nb < NB) r_cd[nb] = cyc;
        chk("cd_data", o_cddata, exp_cddata);
        if (o_cdlast) r_last = cyc;
        nb++;
      end
      if (o_done) begin
        r_done = cyc;
        r_armed_done = o_armed;
      end
    end while (!o_snoop_ready && cyc < 80);
    if (cyc >= 80) chk("snoop_timeout", o_snoop_ready, 1'b1);
    r_nbeats = nb;
    i_crready = 1'b1;
  endtask

  logic [AW-1:0] f_addr[5];
  logic [3:0]    f_snp[5];
  int            f_cr[5];
  int            c_cr[3];
  int            c_shots[3];
  logic          c_armed[3];

  initial begin
    ace_areset = 1'b1; i_enable = 1'b0; i_mode = 2'd1; i_target = 2'd3;
    i_delay = '0; i_shot_count = '0; i_flt_en = '0; i_flt_snp_en = '0;
    i_flt_acsnoop = '0; i_flt_base = '0; i_flt_size = '0;
    i_snoop_valid = 1'b0; i_acaddr = '0; i_acsnoop = '0; i_has_data = 1'b0;
    i_crready = 1'b1; i_cdready = 1'b1;
    exp_crresp = 5'h0B;
    exp_cddata = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    i_crresp = exp_crresp; i_cddata = exp_cddata;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_state", o_state, 3'd0);
    chk("rst_crvalid", o_crvalid, 1'b0);
    chk("rst_cdvalid", o_cdvalid, 1'b0);
    chk("rst_cdlast", o_cdlast, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_armed", o_armed, 1'b0);
    chk("rst_crresp", o_crresp, 5'd0);
    chk("rst_cddata", o_cddata, 128'd0);
    chk("rst_shots", o_shots_left, 16'd0);
    chk("rst_snoop_ready", o_snoop_ready, 1'b0);
    ace_areset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", o_snoop_ready, 1'b1);

    // Unarmed: delay configuration is ignored
    i_target = 2'd0; i_delay = 5;
    do_snoop(44'h40, 4'h0, 1'b1, 0);
    chk("base_filter_state", r_st1, 3'd1);
    chk("base_cr", r_cr, 2);
    chk("base_cd0", r_cd[0], 3);
    chk("base_cd1", r_cd[1], 4);
    chk("base_cd2", r_cd[2], 5);
    chk("base_cd3", r_cd[3], 6);
    chk("base_last", r_last, 6);
    chk("base_done", r_done, 7);
    chk("base_beats", r_nbeats, 4);

    // Reset during beat 2 of 4
    i_mode = 2'd1; i_target = 2'd3;
    arm();
    chk("mid_armed", o_armed, 1'b1);
    i_acaddr = 44'h55; i_has_data = 1'b1; i_snoop_valid = 1'b1;
    @(negedge clk);
    i_snoop_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_beat2_valid", o_cdvalid, 1'b1);
    chk("mid_beat2_last", o_cdlast, 1'b0);
    ace_areset = 1'b1; i_enable = 1'b0;
    @(negedge clk);
    chk("mid_rst_cdvalid", o_cdvalid, 1'b0);
    chk("mid_rst_crvalid", o_crvalid, 1'b0);
    chk("mid_rst_state", o_state, 3'd0);
    chk("mid_rst_armed", o_armed, 1'b0);
    ace_areset = 1'b0;
    @(negedge clk);
    chk("mid_ready", o_snoop_ready, 1'b1);

    // One-shot, target CRVALID, delay 3
    i_mode = 2'd0; i_target = 2'd0; i_delay = 3;
    arm();
    chk("os_armed", o_armed, 1'b1);
    do_snoop(44'h80, 4'h2, 1'b1, 0);
    chk("os1_cr", r_cr, 5);
    chk("os1_done", r_done, 10);
    chk("os1_armed_in_end", r_armed_done, 1'b1);
    chk("os1_armed_after", o_armed, 1'b0);
    do_snoop(44'h80, 4'h2, 1'b1, 0);
    chk("os2_cr", r_cr, 2);
    chk("os2_done", r_done, 7);

    // Continuous, target CDLAST, delay 2
    i_mode = 2'd1; i_target = 2'd2; i_delay = 2;
    arm();
    repeat (2) begin
      do_snoop(44'h100, 4'h0, 1'b1, 0);
      chk("t2_cd0", r_cd[0], 3);
      chk("t2_cd1", r_cd[1], 4);
      chk("t2_cd2", r_cd[2], 5);
      chk("t2_cd3", r_cd[3], 8);
      chk("t2_last", r_last, 8);
      chk("t2_done", r_done, 9);
    end
    chk("t2_armed", o_armed, 1'b1);

    // Target first CDVALID, delay 3; and no data means no delay
    i_target = 2'd1; i_delay = 3;
    do_snoop(44'h100, 4'h0, 1'b1, 0);
    chk("t1_cr", r_cr, 2);
    chk("t1_cd0", r_cd[0], 6);
    chk("t1_last", r_last, 9);
    chk("t1_done", r_done, 10);
    do_snoop(44'h100, 4'h0, 1'b0, 0);
    chk("t1_nodata_cr", r_cr, 2);
    chk("t1_nodata_done", r_done, 3);
    chk("t1_nodata_beats", r_nbeats, 0);

    // Filter slot 1: [0x1000, 0x1100), ACSNOOP 1, delay 4
    i_flt_en = 4'b0010; i_flt_snp_en = 4'b0010; i_flt_acsnoop = 16'h0010;
    i_flt_base = '0; i_flt_base[AW +: AW] = 44'h1000;
    i_flt_size = '0; i_flt_size[AW +: AW] = 44'h100;
    i_mode = 2'd1; i_target = 2'd0; i_delay = 4;
    arm();
    f_addr = '{44'h10FF, 44'h1100, 44'h10FF, 44'h1000, 44'h0FFF};
    f_snp  = '{4'h1, 4'h1, 4'h0, 4'h1, 4'h1};
    f_cr   = '{6, 2, 2, 6, 2};
    for (int i = 0; i < 5; i++) begin
      do_snoop(f_addr[i], f_snp[i], 1'b0, 0);
      chk($sformatf("flt%0d_cr", i), r_cr, f_cr[i]);
    end

    // Counted, 2 shots, delay 1
    i_flt_en = '0; i_mode = 2'd2; i_shot_count = 16'd2; i_target = 2'd0; i_delay = 1;
    arm();
    chk("cnt_shots_load", o_shots_left, 16'd2);
    chk("cnt_armed", o_armed, 1'b1);
    c_cr = '{3, 3, 2}; c_shots = '{1, 0, 0}; c_armed = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_snoop(44'h200, 4'h0, 1'b0, 0);
      chk($sformatf("cnt%0d_cr", i), r_cr, c_cr[i]);
      chk($sformatf("cnt%0d_shots", i), o_shots_left, c_shots[i]);
      chk($sformatf("cnt%0d_armed", i), o_armed, c_armed[i]);
    end
    i_shot_count = 16'd0;
    arm();
    chk("cnt_zero_not_armed", o_armed, 1'b0);

    // CR stall for 5 cycles, then a hit with delay 0
    i_mode = 2'd1; i_target = 2'd3; i_delay = 0; i_shot_count = 16'd7;
    arm();
    chk("stall_shots_load", o_shots_left, 16'd7);
    exp_crresp = 5'h15;
    do_snoop(44'h300, 4'h3, 1'b1, 5);
    chk("stall_cr", r_cr, 2);
    chk("stall_cd0", r_cd[0], 7);
    chk("stall_done", r_done, 11);
    i_target = 2'd0;
    do_snoop(44'h300, 4'h3, 1'b0, 0);
    chk("d0_cr", r_cr, 2);
    chk("d0_done", r_done, 3);
`ifdef SNOOP_DELAY_STATS_EN
    chk("stats_hit", o_hit_count, 32'd1);
    chk("stats_miss", o_miss_count, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
